boardman_initiator: RTL and testbench



---
 rtl/boardman_pkg.sv | 18 +
 rtl/bm_uart_byte.sv | 88 ++++++++
 rtl/boardman_initiator.sv | 115 +++++++++++
 tb/tb_boardman_initiator.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/boardman_pkg.sv
// boardman_pkg: shared constants and types for the boardman serial protocol
package boardman_pkg;
  localparam logic [7:0] BM_ACK_OK = 8'h00;
  localparam int HDR_WE = 7;
  localparam int HDR_SEL_MSB = 3;
  localparam logic [3:0] TX_BYTES_RD = 4'd4;
  localparam logic [3:0] TX_BYTES_WR = 4'd8;
  localparam logic [2:0] RX_BYTES_RD = 3'd4;
  localparam logic [2:0] RX_BYTES_WR = 3'd1;
  typedef enum logic [1:0] {S_IDLE, S_TX, S_RX, S_DONE} bm_state_t;
  function automatic logic [7:0] bm_header(input logic we, input logic [3:0] sel);
    logic [7:0] h;
    h = '0;
    h[HDR_WE] = we;
    h[HDR_SEL_MSB -: 4] = we ? sel : 4'h0;
    return h;
  endfunction
endpackage

// File: rtl/bm_uart_byte.sv
// bm_uart_byte: 8N1 byte transmitter and receiver sharing one bit period
module bm_uart_byte #(
  parameter int BIT_CYC = 434
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  output logic       tx_rdy,
  output logic       tx,
  input  logic       rx,
  output logic       rx_valid,
  output logic [7:0] rx_data,
  output logic       rx_frame_err
);
  localparam int CW = $clog2(BIT_CYC);
  localparam logic [CW-1:0] LAST = CW'(BIT_CYC - 1);
  localparam logic [CW-1:0] HALF = CW'(BIT_CYC / 2 - 1);
  logic          tx_busy;
  logic          tx_end;
  logic [8:0]    tx_sh;
  logic [3:0]    tx_bit;
  logic [CW-1:0] tx_cyc;
  logic          rx_s1;
  logic          rx_s2;
  logic          rx_p;
  logic          rx_on;
  logic          rx_tick;
  logic [3:0]    rx_bit;
  logic [CW-1:0] rx_cyc;
  logic [7:0]    rx_sh;
  // ready during the last stop-bit cycle so consecutive bytes have no gap
  assign tx_end = tx_bit == 4'd9 && tx_cyc == LAST;
  assign tx_rdy = !tx_busy || tx_end;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      tx <= 1'b1;
      tx_busy <= 1'b0;
      tx_sh <= '0;
      tx_bit <= '0;
      tx_cyc <= '0;
    end else if (tx_start && tx_rdy) begin
      tx <= 1'b0;
      tx_busy <= 1'b1;
      tx_sh <= {1'b1, tx_data};
      tx_bit <= '0;
      tx_cyc <= '0;
    end else if (tx_busy) begin
      tx_cyc <= tx_cyc == LAST ? '0 : tx_cyc + 1'b1;
      if (tx_cyc == LAST) begin
        tx <= tx_end ? 1'b1 : tx_sh[0];
        tx_busy <= !tx_end;
        tx_sh <= tx_sh >> 1;
        tx_bit <= tx_bit + 1'b1;
      end
    end
  // bit 0 is the half-period start re-check, 1..8 data, 9 stop
  assign rx_tick = rx_cyc == (rx_bit == 4'd0 ? HALF : LAST);
  assign rx_data = rx_sh;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      {rx_p, rx_s2, rx_s1} <= 3'b111;
      rx_on <= 1'b0;
      rx_bit <= '0;
      rx_cyc <= '0;
      rx_sh <= '0;
      rx_valid <= 1'b0;
      rx_frame_err <= 1'b0;
    end else begin
      {rx_p, rx_s2, rx_s1} <= {rx_s2, rx_s1, rx};
      rx_valid <= 1'b0;
      rx_frame_err <= 1'b0;
      if (!rx_on) begin
        rx_on <= rx_p && !rx_s2;
        rx_bit <= '0;
        rx_cyc <= '0;
      end else if (rx_tick) begin
        rx_cyc <= '0;
        rx_bit <= rx_bit + 1'b1;
        rx_on <= !(rx_bit == 4'd0 && rx_s2) && rx_bit != 4'd9;
        rx_valid <= rx_bit == 4'd9 && rx_s2;
        rx_frame_err <= rx_bit == 4'd9 && !rx_s2;
        if (rx_bit != 4'd0 && rx_bit != 4'd9) rx_sh <= {rx_s2, rx_sh[7:1]};
      end else begin
        rx_cyc <= rx_cyc + 1'b1;
      end
    end
endmodule

// File: rtl/boardman_initiator.sv
// boardman_initiator: host-side boardman master, one register transaction per
// request serialized as a request frame, response checked and returned
module boardman_initiator
  import boardman_pkg::*;
#(
  parameter int CLOCK_RATE  = 50000000,
  parameter int BAUD_RATE   = 115200,
  parameter int TIMEOUT_CYC = 1000000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  output logic        ready_o,
  input  logic        we_i,
  input  logic [21:0] adr_i,
  input  logic [3:0]  sel_i,
  input  logic [31:0] dat_i,
  output logic        done_o,
  output logic        err_o,
  output logic [31:0] dat_o,
  output logic        BM_TX,
  input  logic        BM_RX
);
  localparam int BIT_CYC = CLOCK_RATE / BAUD_RATE;
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);
  logic [1:0]    rst_q;
  logic          rst;
  bm_state_t     state;
  bm_state_t     state_n;
  logic          we;
  logic          err;
  logic [63:0]   tx_sh;
  logic [3:0]    tx_cnt;
  logic [2:0]    rx_cnt;
  logic [31:0]   rx_sh;
  logic [TW-1:0] tmo;
  logic          tx_start;
  logic          tx_rdy;
  logic          rx_valid;
  logic          rx_ferr;
  logic [7:0]    rx_data;
  logic          tmo_hit;
  logic          last_rx;
  logic          finish;
  logic          ok;
  // reset asserts immediately, releases two clocks after rst_i drops
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) rst_q <= 2'b11;
    else rst_q <= {rst_q[0], 1'b0};
  assign rst = rst_q[1];
  bm_uart_byte #(.BIT_CYC(BIT_CYC)) u_uart (
    .clk(clk_i),
    .rst(rst),
    .tx_start(tx_start),
    .tx_data(tx_sh[63:56]),
    .tx_rdy(tx_rdy),
    .tx(BM_TX),
    .rx(BM_RX),
    .rx_valid(rx_valid),
    .rx_data(rx_data),
    .rx_frame_err(rx_ferr)
  );
  assign tx_start = state == S_TX && tx_cnt != 4'd0 && tx_rdy;
  assign tmo_hit = tmo == TMO_LAST;
  assign last_rx = rx_valid && rx_cnt == 3'd1;
  assign finish = tmo_hit || rx_ferr || last_rx;
  assign ok = last_rx && !tmo_hit && !(we && rx_data != BM_ACK_OK);
  assign ready_o = state == S_IDLE;
  assign done_o = state == S_DONE;
  assign err_o = done_o && err;
  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:  state_n = req_i ? S_TX : S_IDLE;
      S_TX:    state_n = tx_cnt == 4'd0 && tx_rdy ? S_RX : S_TX;
      S_RX:    state_n = finish ? S_DONE : S_RX;
      default: state_n = S_IDLE;
    endcase
  end
  always_ff @(posedge clk_i or posedge rst)
    if (rst) begin
      state <= S_IDLE;
      we <= 1'b0;
      err <= 1'b0;
      tx_sh <= '0;
      tx_cnt <= '0;
      rx_cnt <= '0;
      rx_sh <= '0;
      tmo <= '0;
      dat_o <= '0;
    end else begin
      state <= state_n;
      if (state == S_IDLE && req_i) begin
        we <= we_i;
        tx_sh <= {bm_header(we_i, sel_i), 2'b00, adr_i, dat_i};
        tx_cnt <= we_i ? TX_BYTES_WR : TX_BYTES_RD;
        rx_cnt <= we_i ? RX_BYTES_WR : RX_BYTES_RD;
      end
      if (tx_start) begin
        tx_sh <= tx_sh << 8;
        tx_cnt <= tx_cnt - 1'b1;
      end
      // runs across all response bytes, cleared whenever not receiving
      tmo <= state == S_RX ? tmo + 1'b1 : '0;
      if (state == S_RX && rx_valid) begin
        rx_sh <= {rx_sh[23:0], rx_data};
        rx_cnt <= rx_cnt - 1'b1;
      end
      if (state == S_RX && finish) begin
        err <= !ok;
        if (ok && !we) dat_o <= {rx_sh[23:0], rx_data};
      end
    end
endmodule

// File: tb/tb_boardman_initiator.sv
// tb_boardman_initiator: directed checks of framing, responses, timeout and reset
module tb_boardman_initiator;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rstd = 1'b1;
  logic req = 1'b0;
  logic reqd = 1'b0;
  logic we = 1'b0;
  logic rx = 1'b1;
  logic rxd = 1'b1;
  logic [21:0] adr = '0;
  logic [3:0] sel = '0;
  logic [31:0] dat = '0;
  logic ready, done, err, tx, readyd, doned, errd, txd;
  logic [31:0] dato, datod;
  int total = 0;
  int bad = 0;
  int n_done = 0;
  int n_doned = 0;
  logic last_err, last_errd;
  logic [31:0] last_dat, last_datd;

  always #5 clk = ~clk;

  boardman_initiator #(.CLOCK_RATE(1152000), .BAUD_RATE(115200), .TIMEOUT_CYC(5000)) dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .ready_o(ready), .we_i(we), .adr_i(adr),
    .sel_i(sel), .dat_i(dat), .done_o(done), .err_o(err), .dat_o(dato), .BM_TX(tx), .BM_RX(rx)
  );

  boardman_initiator dutd (
    .clk_i(clk), .rst_i(rstd), .req_i(reqd), .ready_o(readyd), .we_i(we), .adr_i(adr),
    .sel_i(sel), .dat_i(dat), .done_o(doned), .err_o(errd), .dat_o(datod), .BM_TX(txd), .BM_RX(rxd)
  );

  always @(negedge clk) begin
    if (done) begin
      n_done++;
      last_err = err;
      last_dat = dato;
    end
    if (doned) begin
      n_doned++;
      last_errd = errd;
      last_datd = datod;
    end
  end

  initial begin
    #950000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1, "watchdog");
  end

  task automatic start_req(input bit d, input logic w, input logic [21:0] a, input logic [3:0] s, input logic [31:0] x);
    we = w;
    adr = a;
    sel = s;
    dat = x;
    if (d) reqd = 1'b1;
    else req = 1'b1;
    @(posedge clk);
    #1;
    req = 1'b0;
    reqd = 1'b0;
  endtask

  task automatic get_frame(input bit d, input int n, output logic [63:0] f, output bit ok);
    int bc;
    bit got;
    logic [7:0] b;
    bc = d ? 434 : 10;
    f = '0;
    ok = 1'b1;
    for (int j = 0; j < n; j++) begin
      got = 1'b0;
      for (int i = 0; i < 20 * bc && !got; i++) begin
        @(posedge clk);
        #1;
        got = (d ? txd : tx) == 1'b0;
      end
      if (!got) begin
        ok = 1'b0;
        return;
      end
      repeat (bc / 2) @(posedge clk);
      #1;
      for (int k = 0; k < 8; k++) begin
        repeat (bc) @(posedge clk);
        #1;
        b[k] = d ? txd : tx;
      end
      f = {f[55:0], b};
      repeat (bc) @(posedge clk);
      #1;
      if ((d ? txd : tx) !== 1'b1) ok = 1'b0;
    end
  endtask

  task automatic put_frame(input bit d, input int n, input logic [31:0] v, input int bad_idx);
    int bc;
    logic [9:0] frm;
    bc = d ? 434 : 10;
    for (int j = 0; j < n; j++) begin
      frm = {j == bad_idx ? 1'b0 : 1'b1, v[8*(n-1-j) +: 8], 1'b0};
      for (int k = 0; k < 10; k++) begin
        if (d) rxd = frm[k];
        else rx = frm[k];
        repeat (bc) @(posedge clk);
        #1;
      end
    end
    rx = 1'b1;
    rxd = 1'b1;
  endtask

  task automatic wait_done(input bit d, input int prev);
    for (int i = 0; i < 20000 && (d ? n_doned : n_done) == prev; i++) begin
      @(posedge clk);
      #1;
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    total++; if (tx !== 1'b1) begin bad++; $display("FAIL reset_tx: got %b want 1", tx); end
    total++; if (ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b want 1", ready); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", done); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL reset_err: got %b want 0", err); end
    total++; if (dato !== 32'h0) begin bad++; $display("FAIL reset_dat: got %h want 00000000", dato); end
    total++; if (txd !== 1'b1 || readyd !== 1'b1) begin bad++; $display("FAIL reset_default: tx %b ready %b want 1 1", txd, readyd); end
  endtask

  task automatic test_read();
    int p;
    bit ok;
    logic [63:0] f;
    p = n_done;
    start_req(0, 1'b0, 22'h000010, 4'hF, 32'hFFFFFFFF);
    total++; if (ready !== 1'b0) begin bad++; $display("FAIL read_ready_drop: got %b want 0", ready); end
    get_frame(0, 4, f, ok);
    total++; if (!ok || f !== 64'h00000010) begin bad++; $display("FAIL read_frame: got %h ok %b want 00000010", f, ok); end
    repeat (10) @(posedge clk);
    #1;
    put_frame(0, 4, 32'hDEADBEEF, -1);
    wait_done(0, p);
    total++; if (n_done !== p + 1) begin bad++; $display("FAIL read_done_count: got %0d want %0d", n_done, p + 1); end
    total++; if (last_err !== 1'b0) begin bad++; $display("FAIL read_err: got %b want 0", last_err); end
    total++; if (last_dat !== 32'hDEADBEEF) begin bad++; $display("FAIL read_dat: got %h want deadbeef", last_dat); end
    total++; if (ready !== 1'b1 || dato !== 32'hDEADBEEF) begin bad++; $display("FAIL read_after: ready %b dat %h want 1 deadbeef", ready, dato); end
  endtask

  task automatic test_write_ok();
    int p;
    bit ok;
    logic [63:0] f;
    p = n_done;
    start_req(0, 1'b1, 22'h3FFFFC, 4'hF, 32'h12345678);
    get_frame(0, 8, f, ok);
    total++; if (!ok || f !== 64'h8F3FFFFC12345678) begin bad++; $display("FAIL write_frame: got %h ok %b want 8f3ffffc12345678", f, ok); end
    repeat (10) @(posedge clk);
    #1;
    put_frame(0, 1, 32'h00, -1);
    wait_done(0, p);
    total++; if (n_done !== p + 1) begin bad++; $display("FAIL write_done_count: got %0d want %0d", n_done, p + 1); end
    total++; if (last_err !== 1'b0) begin bad++; $display("FAIL write_err: got %b want 0", last_err); end
    total++; if (last_dat !== 32'hDEADBEEF) begin bad++; $display("FAIL write_dat_kept: got %h want deadbeef", last_dat); end
  endtask

  task automatic test_write_nak();
    int p;
    bit ok;
    logic [63:0] f;
    p = n_done;
    start_req(0, 1'b1, 22'h000004, 4'h3, 32'hA5A5A5A5);
    get_frame(0, 8, f, ok);
    total++; if (!ok || f !== 64'h83000004A5A5A5A5) begin bad++; $display("FAIL nak_frame: got %h ok %b want 83000004a5a5a5a5", f, ok); end
    repeat (10) @(posedge clk);
    #1;
    put_frame(0, 1, 32'h01, -1);
    wait_done(0, p);
    total++; if (n_done !== p + 1) begin bad++; $display("FAIL nak_done_count: got %0d want %0d", n_done, p + 1); end
    total++; if (last_err !== 1'b1) begin bad++; $display("FAIL nak_err: got %b want 1", last_err); end
    total++; if (dato !== 32'hDEADBEEF) begin bad++; $display("FAIL nak_dat_kept: got %h want deadbeef", dato); end
  endtask

  task automatic test_timeout();
    int n;
    int p;
    bit ok;
    logic [63:0] f;
    start_req(0, 1'b0, 22'h2ABCDE, 4'h0, 32'h0);
    n = 0;
    while (done !== 1'b1 && n < 10000) begin
      @(posedge clk);
      #1;
      n++;
    end
    // accept edge + start edge, 40 bit times of frame, then TIMEOUT_CYC
    total++; if (n !== 5401) begin bad++; $display("FAIL timeout_cycles: got %0d want 5401", n); end
    total++; if (err !== 1'b1) begin bad++; $display("FAIL timeout_err: got %b want 1", err); end
    total++; if (dato !== 32'hDEADBEEF) begin bad++; $display("FAIL timeout_dat_kept: got %h want deadbeef", dato); end
    @(posedge clk);
    #1;
    total++; if (ready !== 1'b1 || done !== 1'b0) begin bad++; $display("FAIL timeout_pulse: ready %b done %b want 1 0", ready, done); end
    p = n_done;
    start_req(0, 1'b0, 22'h000020, 4'h0, 32'h0);
    get_frame(0, 4, f, ok);
    total++; if (!ok || f !== 64'h00000020) begin bad++; $display("FAIL retry_frame: got %h ok %b want 00000020", f, ok); end
    repeat (10) @(posedge clk);
    #1;
    put_frame(0, 4, 32'h01020304, -1);
    wait_done(0, p);
    total++; if (n_done !== p + 1 || last_err !== 1'b0 || last_dat !== 32'h01020304) begin
      bad++; $display("FAIL retry_result: count %0d err %b dat %h want %0d 0 01020304", n_done, last_err, last_dat, p + 1);
    end
  endtask

  task automatic test_framing();
    int p;
    bit ok;
    logic [63:0] f;
    p = n_done;
    start_req(0, 1'b0, 22'h00ABCD, 4'h0, 32'h0);
    get_frame(0, 4, f, ok);
    total++; if (!ok || f !== 64'h0000ABCD) begin bad++; $display("FAIL frm_frame: got %h ok %b want 0000abcd", f, ok); end
    repeat (10) @(posedge clk);
    #1;
    put_frame(0, 2, 32'h0000AABB, 1);
    wait_done(0, p);
    total++; if (n_done !== p + 1) begin bad++; $display("FAIL frm_done_count: got %0d want %0d", n_done, p + 1); end
    total++; if (last_err !== 1'b1) begin bad++; $display("FAIL frm_err: got %b want 1", last_err); end
    total++; if (dato !== 32'h01020304) begin bad++; $display("FAIL frm_dat_kept: got %h want 01020304", dato); end
    p = n_done;
    put_frame(0, 2, 32'h00005AC3, -1);
    repeat (50) @(posedge clk);
    #1;
    total++; if (n_done !== p || ready !== 1'b1) begin bad++; $display("FAIL idle_stray: count %0d ready %b want %0d 1", n_done, ready, p); end
  endtask

  task automatic test_reset_mid_tx();
    int n;
    int m;
    int p;
    bit ok;
    logic [63:0] f;
    start_req(1, 1'b0, 22'h0F0F0F, 4'h0, 32'h0);
    repeat (1 + 20 * 434 + 100) @(posedge clk);
    #1;
    total++; if (txd !== 1'b0 || readyd !== 1'b0) begin bad++; $display("FAIL mid_tx_state: tx %b ready %b want 0 0", txd, readyd); end
    rstd = 1'b1;
    #1;
    total++; if (txd !== 1'b1 || readyd !== 1'b1) begin bad++; $display("FAIL mid_tx_reset: tx %b ready %b want 1 1", txd, readyd); end
    @(posedge clk);
    #1;
    rstd = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    total++; if (txd !== 1'b1 || readyd !== 1'b1) begin bad++; $display("FAIL post_reset_idle: tx %b ready %b want 1 1", txd, readyd); end
    p = n_doned;
    start_req(1, 1'b0, 22'h000155, 4'h0, 32'h0);
    n = 0;
    while (txd === 1'b1 && n < 10) begin
      @(posedge clk);
      #1;
      n++;
    end
    total++; if (n !== 1) begin bad++; $display("FAIL start_latency: got %0d want 1", n); end
    m = 0;
    while (txd === 1'b0 && m < 5000) begin
      @(posedge clk);
      #1;
      m++;
    end
    // header 00: start bit plus 8 zero data bits
    total++; if (m !== 9 * 434) begin bad++; $display("FAIL bit_period: got %0d want %0d", m, 9 * 434); end
    get_frame(1, 3, f, ok);
    total++; if (!ok || f !== 64'h000155) begin bad++; $display("FAIL def_frame: got %h ok %b want 000155", f, ok); end
    repeat (434) @(posedge clk);
    #1;
    put_frame(1, 4, 32'hCAFEF00D, -1);
    wait_done(1, p);
    total++; if (n_doned !== p + 1 || last_errd !== 1'b0 || last_datd !== 32'hCAFEF00D) begin
      bad++; $display("FAIL def_result: count %0d err %b dat %h want %0d 0 cafef00d", n_doned, last_errd, last_datd, p + 1);
    end
  endtask

  initial begin
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b0;
    rstd = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    test_reset();
    test_read();
    test_write_ok();
    test_write_nak();
    test_timeout();
    test_framing();
    test_reset_mid_tx();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
